// File: rtl/ni_pkg.sv
// ni_pkg: shared network-interface types, header layout and 1-of-4 encoder
package ni_pkg;
  typedef enum logic [2:0] {IDLE, HEAD, HEAD_RTZ, DATA, DATA_RTZ, DWAIT, TAIL, TAIL_RTZ} ni_tx_st_t;
  localparam int HDR_X_SC = 0;
  localparam int HDR_Y_SC = 2;
  function automatic logic [3:0] enc1of4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction
endpackage

// File: rtl/ni_tx_frame_if.sv
// ni_tx_frame_if: core word stream, QDI rails/ack and status of the NI transmitter
// slave: the transmitter (takes tx_* and oa, drives tx_ready, o0..o4, busy, frame_done)
// master: the core/router side, opposite directions
interface ni_tx_frame_if #(parameter int DW = 16);
  localparam int SCN = DW / 2;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_last;
  logic [3:0]    tx_dst_x;
  logic [3:0]    tx_dst_y;
  logic [SCN-1:0] o0, o1, o2, o3;
  logic          o4;
  logic          oa;
  logic          busy;
  logic          frame_done;
  modport slave (
    input  tx_valid, tx_data, tx_last, tx_dst_x, tx_dst_y, oa,
    output tx_ready, o0, o1, o2, o3, o4, busy, frame_done
  );
  modport master (
    output tx_valid, tx_data, tx_last, tx_dst_x, tx_dst_y, oa,
    input  tx_ready, o0, o1, o2, o3, o4, busy, frame_done
  );
endinterface

// File: rtl/sync_ff.sv
// sync_ff: N-stage flop synchroniser for a single asynchronous bit
// clk, rst (sync, active-high), d async input, q synchronised output
module sync_ff #(parameter int N = 2) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [N-1:0] r;
  always_ff @(posedge clk) r <= rst ? '0 : {r[N-2:0], d};
  assign q = r[N-1];
endmodule

// File: rtl/ni_tx_frame.sv
// ni_tx_frame: turns a valid/ready word stream into QDI 1-of-4 four-phase flits (head, data..., eof)
// clk, rst (sync, active-high); bus.slave: tx_valid/tx_ready/tx_data/tx_last/tx_dst_x/tx_dst_y core side,
// o0..o3 1-of-4 rails and o4 eof rail out, oa async ack in, busy and frame_done status out
module ni_tx_frame
  import ni_pkg::*;
#(
  parameter int DW   = 16,
  parameter int SYNC = 2
) (
  input logic clk,
  input logic rst,
  ni_tx_frame_if.slave bus
);
  localparam int SCN = DW / 2;
  ni_tx_st_t state, state_n;
  logic [3:0][SCN-1:0] rails, rails_n, enc;
  logic [DW-1:0] buf_data, src, hv;
  logic buf_last, eof, eof_n, busy, busy_n, done, done_n, oa_s, accept, cap;
  sync_ff #(.N(SYNC)) u_sync (.clk(clk), .rst(rst), .d(bus.oa), .q(oa_s));
  // one encoder serves all flits: head code from the live dst in IDLE, live word in DWAIT, buffer otherwise
  always_comb begin
    hv = '0;
    hv[2*HDR_X_SC +: 4] = bus.tx_dst_x;
    hv[2*HDR_Y_SC +: 4] = bus.tx_dst_y;
    src = state == IDLE ? hv : state == DWAIT ? bus.tx_data : buf_data;
  end
  for (genvar j = 0; j < SCN; j++) begin : g_enc
    assign {enc[3][j], enc[2][j], enc[1][j], enc[0][j]} = enc1of4(src[2*j +: 2]);
  end
  // rst also holds tx_ready low so nothing is accepted on a reset edge
  assign bus.tx_ready = (state == IDLE || state == DWAIT) && !oa_s && !rst;
  assign accept = bus.tx_valid && bus.tx_ready;
  always_comb begin
    state_n = state;
    rails_n = rails;
    eof_n = eof;
    busy_n = busy;
    done_n = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE:     if (accept) begin state_n = HEAD; rails_n = enc; busy_n = 1'b1; cap = 1'b1; end
      HEAD:     if (oa_s) begin state_n = HEAD_RTZ; rails_n = '0; end
      HEAD_RTZ: if (!oa_s) begin state_n = DATA; rails_n = enc; end
      DATA:     if (oa_s) begin state_n = DATA_RTZ; rails_n = '0; end
      DATA_RTZ: if (!oa_s) begin state_n = buf_last ? TAIL : DWAIT; eof_n = buf_last; end
      DWAIT:    if (accept) begin state_n = DATA; rails_n = enc; cap = 1'b1; end
      TAIL:     if (oa_s) begin state_n = TAIL_RTZ; eof_n = 1'b0; end
      TAIL_RTZ: if (!oa_s) begin state_n = IDLE; busy_n = 1'b0; done_n = 1'b1; end
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rails <= '0;
      eof <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      buf_data <= '0;
      buf_last <= 1'b0;
    end else begin
      state <= state_n;
      rails <= rails_n;
      eof <= eof_n;
      busy <= busy_n;
      done <= done_n;
      if (cap) begin
        buf_data <= bus.tx_data;
        buf_last <= bus.tx_last;
      end
    end
  end
  assign bus.o0 = rails[0];
  assign bus.o1 = rails[1];
  assign bus.o2 = rails[2];
  assign bus.o3 = rails[3];
  assign bus.o4 = eof;
  assign bus.busy = busy;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_ni_tx_frame.sv
// tb_ni_tx_frame: random-delay 4-phase responder plus token-level frame model for ni_tx_frame
module tb_ni_tx_frame;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ni_tx_frame_if #(.DW(DW)) bus ();
  ni_tx_frame #(.DW(DW), .SYNC(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int viol = 0;
  int pre_delay = -1;
  int ack_hold = 0;
  logic [DW:0] tok_q[$];
  logic [DW:0] exp_q[$];
  logic [DW-1:0] wq[$];
  time done_t = 0;
  time acc_t = 0;
  logic acc_oa = 1'b0;
  localparam logic [DW:0] EOF_TOK = 17'h10000;

  function automatic bit spacer();
    return {bus.o4, bus.o3, bus.o2, bus.o1, bus.o0} == '0;
  endfunction
  function automatic bit tok_ok();
    if (bus.o4) return {bus.o3, bus.o2, bus.o1, bus.o0} == '0;
    for (int j = 0; j < DW / 2; j++)
      if (int'(bus.o0[j]) + int'(bus.o1[j]) + int'(bus.o2[j]) + int'(bus.o3[j]) != 1) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [DW:0] tok_val();
    logic [DW:0] v = '0;
    if (bus.o4) return EOF_TOK;
    for (int j = 0; j < DW / 2; j++)
      v[2*j +: 2] = bus.o1[j] ? 2'd1 : bus.o2[j] ? 2'd2 : bus.o3[j] ? 2'd3 : 2'd0;
    return v;
  endfunction
  function automatic bit q_eq();
    if (tok_q.size() != exp_q.size()) return 1'b0;
    foreach (tok_q[i]) if (tok_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // router input buffer: logs each token, acks after a random delay, releases after spacer (+hold)
  initial begin
    bus.oa = 1'b0;
    forever begin
      @(negedge clk);
      if (spacer() === 1'b0) begin
        if (!tok_ok()) viol++;
        tok_q.push_back(tok_val());
        repeat (pre_delay < 0 ? int'($urandom_range(0, 20)) : pre_delay) @(negedge clk);
        bus.oa = 1'b1;
        for (int i = 0; i < 2000 && !spacer(); i++) @(negedge clk);
        if (!spacer()) viol++;
        repeat (ack_hold + int'($urandom_range(0, 20))) begin
          @(negedge clk);
          if (!spacer()) viol++;
        end
        bus.oa = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_t = $time;
    if (bus.tx_ready === 1'b1 && !spacer()) viol++;
  end

  task automatic clr();
    tok_q.delete();
    exp_q.delete();
    viol = 0;
  endtask

  task automatic send_frame(input logic [3:0] x, input logic [3:0] y, input int n, input int gap);
    int to;
    exp_q.push_back(17'(x) | (17'(y) << 4));
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data = wq[i];
      bus.tx_last = (i == n - 1);
      bus.tx_dst_x = i == 0 ? x : 4'($urandom);
      bus.tx_dst_y = i == 0 ? y : 4'($urandom);
      to = 0;
      while (bus.tx_ready !== 1'b1 && to < 5000) begin
        @(negedge clk);
        to++;
      end
      checks++;
      if (bus.tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL accept_timeout word %0d: tx_ready=%b required 1", i, bus.tx_ready);
      end
      @(posedge clk);
      if (i == 0) begin
        acc_t = $time;
        acc_oa = bus.oa;
      end
      @(negedge clk);
      bus.tx_valid = 1'b0;
      exp_q.push_back({1'b0, wq[i]});
    end
    exp_q.push_back(EOF_TOK);
  endtask

  task automatic wait_done(output logic seen, output logic b);
    int to = 0;
    while (bus.frame_done !== 1'b1 && to < 20000) begin
      @(negedge clk);
      to++;
    end
    seen = bus.frame_done;
    b = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (spacer() !== 1'b1) begin errors++; $display("FAIL reset_rails: o4..o0=%h required 0", {bus.o4, bus.o3, bus.o2, bus.o1, bus.o0}); end
    checks++;
    if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: %b required 0", bus.tx_ready); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", bus.busy); end
    checks++;
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: %b required 0", bus.frame_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic seen, b;
    clr();
    wq = '{16'h1B2E};
    send_frame(4'd2, 4'd3, 1, 0);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_hi: %b required 1", bus.busy); end
    wait_done(seen, b);
    checks++;
    if (seen !== 1'b1 || b !== 1'b0) begin errors++; $display("FAIL single_done: frame_done=%b busy=%b required 1 0", seen, b); end
    @(negedge clk);
    checks++;
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL single_pulse: frame_done=%b required 0", bus.frame_done); end
    checks++;
    if (!q_eq()) begin errors++; $display("FAIL single_tokens: got %0d tokens (%h %h) required %0d (%h %h)", tok_q.size(), tok_q.size() > 0 ? tok_q[0] : 17'h0, tok_q.size() > 1 ? tok_q[1] : 17'h0, exp_q.size(), exp_q[0], exp_q[1]); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL single_protocol: %0d violations required 0", viol); end
  endtask

  task automatic test_multi();
    logic seen, b;
    clr();
    wq = '{16'h0000, 16'hFFFF, 16'hA5A5, 16'h5A5A};
    send_frame(4'($urandom), 4'($urandom), 4, 7);
    wait_done(seen, b);
    checks++;
    if (seen !== 1'b1 || b !== 1'b0) begin errors++; $display("FAIL multi_done: frame_done=%b busy=%b required 1 0", seen, b); end
    checks++;
    if (tok_q.size() != 6 || !q_eq()) begin errors++; $display("FAIL multi_tokens: got %0d tokens required %0d in order", tok_q.size(), exp_q.size()); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL multi_protocol: %0d violations required 0", viol); end
  endtask

  task automatic test_random();
    logic seen, b;
    int n;
    for (int f = 0; f < 4; f++) begin
      clr();
      n = $urandom_range(1, 5);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      send_frame(4'($urandom), 4'($urandom), n, $urandom_range(0, 10));
      wait_done(seen, b);
      checks++;
      if (seen !== 1'b1 || b !== 1'b0) begin errors++; $display("FAIL random%0d_done: frame_done=%b busy=%b required 1 0", f, seen, b); end
      checks++;
      if (!q_eq()) begin errors++; $display("FAIL random%0d_tokens: got %0d tokens required %0d", f, tok_q.size(), exp_q.size()); end
      checks++;
      if (viol != 0) begin errors++; $display("FAIL random%0d_protocol: %0d violations required 0", f, viol); end
    end
  endtask

  task automatic test_back_to_back();
    logic seen, b;
    time done_a, acc_b;
    clr();
    done_t = 0;
    wq = '{16'($urandom), 16'($urandom)};
    send_frame(4'd15, 4'd15, 2, 0);
    wq = '{16'($urandom)};
    send_frame(4'd0, 4'd0, 1, 0);
    done_a = done_t;
    acc_b = acc_t;
    checks++;
    if (done_a == 0 || acc_b <= done_a) begin errors++; $display("FAIL b2b_order: second accept at %0t, first frame_done at %0t, required accept after done", acc_b, done_a); end
    checks++;
    if (acc_oa !== 1'b0) begin errors++; $display("FAIL b2b_oa: oa=%b at second accept required 0", acc_oa); end
    wait_done(seen, b);
    checks++;
    if (seen !== 1'b1 || b !== 1'b0) begin errors++; $display("FAIL b2b_done: frame_done=%b busy=%b required 1 0", seen, b); end
    checks++;
    if (!q_eq()) begin errors++; $display("FAIL b2b_tokens: got %0d tokens required %0d", tok_q.size(), exp_q.size()); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL b2b_protocol: %0d violations required 0", viol); end
  endtask

  task automatic test_slow_ack();
    logic seen, b;
    time t0;
    clr();
    ack_hold = 50;
    t0 = $time;
    wq = '{16'($urandom), 16'($urandom)};
    send_frame(4'($urandom), 4'($urandom), 2, 0);
    wait_done(seen, b);
    ack_hold = 0;
    checks++;
    if (seen !== 1'b1 || b !== 1'b0) begin errors++; $display("FAIL slow_done: frame_done=%b busy=%b required 1 0", seen, b); end
    checks++;
    if (($time - t0) / 10 < 200) begin errors++; $display("FAIL slow_duration: %0d cycles required >= 200", ($time - t0) / 10); end
    checks++;
    if (!q_eq()) begin errors++; $display("FAIL slow_tokens: got %0d tokens required %0d", tok_q.size(), exp_q.size()); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL slow_protocol: %0d violations required 0", viol); end
  endtask

  task automatic test_reset_data();
    logic seen, b;
    int to;
    clr();
    pre_delay = 60;
    bus.tx_valid = 1'b1;
    bus.tx_data = 16'($urandom);
    bus.tx_last = 1'b0;
    bus.tx_dst_x = 4'($urandom);
    bus.tx_dst_y = 4'($urandom);
    to = 0;
    while (bus.tx_ready !== 1'b1 && to < 5000) begin @(negedge clk); to++; end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    to = 0;
    while (tok_q.size() < 2 && to < 2000) begin @(negedge clk); to++; end
    checks++;
    if (tok_q.size() < 2 || spacer() !== 1'b0) begin errors++; $display("FAIL rstdata_reach: %0d tokens, spacer=%b, required 2 tokens and data on rails", tok_q.size(), spacer()); end
    ack_hold = 10;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (spacer() !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstdata_drop: spacer=%b busy=%b required 1 0", spacer(), bus.busy); end
    rst = 1'b0;
    pre_delay = -1;
    to = 0;
    while (bus.oa !== 1'b1 && to < 200) begin @(negedge clk); to++; end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oa !== 1'b1 || bus.tx_ready !== 1'b0) begin errors++; $display("FAIL rstdata_gate: oa=%b tx_ready=%b required 1 0", bus.oa, bus.tx_ready); end
    clr();
    wq = '{16'($urandom), 16'($urandom), 16'($urandom)};
    send_frame(4'($urandom), 4'($urandom), 3, 2);
    checks++;
    if (acc_oa !== 1'b0) begin errors++; $display("FAIL rstdata_accept_oa: oa=%b at accept required 0", acc_oa); end
    wait_done(seen, b);
    ack_hold = 0;
    checks++;
    if (seen !== 1'b1 || b !== 1'b0) begin errors++; $display("FAIL rstdata_done: frame_done=%b busy=%b required 1 0", seen, b); end
    checks++;
    if (!q_eq()) begin errors++; $display("FAIL rstdata_tokens: got %0d tokens required %0d", tok_q.size(), exp_q.size()); end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL rstdata_protocol: %0d violations required 0", viol); end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    bus.tx_last = 1'b0;
    bus.tx_dst_x = '0;
    bus.tx_dst_y = '0;
    test_reset();
    test_single();
    test_multi();
    test_random();
    test_back_to_back();
    test_slow_ack();
    test_reset_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
